// File: rtl/mux_scan_ctrl.sv
// Sequencer that walks an 8:1 bit-select mux through all inputs, samples its
// output after a settle delay per select value, and returns the byte over valid/ready.
module mux_scan_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter bit          MSB_FIRST     = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mux_out,
  output logic [2:0] sel,
  output logic       busy,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready
);

  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

  localparam logic [2:0] FIRST_SEL     = MSB_FIRST ? 3'd7 : 3'd0;
  localparam logic [3:0] SETTLE_RELOAD = 4'(SETTLE_CYCLES);

  state_t     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [3:0] settle_q, settle_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] data_q, data_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= 3'd0;
      settle_q <= 4'd0;
      bit_q    <= 3'd0;
      data_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      settle_q <= settle_d;
      bit_q    <= bit_d;
      data_q   <= data_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    settle_d = settle_q;
    bit_d    = bit_q;
    data_d   = data_q;
    unique case (state_q)
      IDLE: begin
        sel_d = 3'd0;
        if (start) begin
          state_d  = SETTLE;
          sel_d    = FIRST_SEL;
          settle_d = SETTLE_RELOAD;
          bit_d    = 3'd0;
        end
      end
      SETTLE: begin
        if (settle_q != 4'd0) begin
          settle_d = settle_q - 4'd1;
        end else begin
          // Store by select index so bit k always reflects mux input k.
          data_d[sel_q] = mux_out;
          if (bit_q != 3'd7) begin
            sel_d    = MSB_FIRST ? (sel_q - 3'd1) : (sel_q + 3'd1);
            settle_d = SETTLE_RELOAD;
            bit_d    = bit_q + 3'd1;
          end else begin
            state_d = DONE;
            sel_d   = 3'd0;
          end
        end
      end
      DONE: begin
        if (data_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sel        = sel_q;
  assign busy       = (state_q == SETTLE);
  assign data_valid = (state_q == DONE);
  assign data_out   = data_q;

endmodule
